tile_swap_controller: RTL and testbench
=======================================

Name: tile_swap_controller

Overview:
- Owns the 3x3 board of tile codes for the tile-matching game.
- Sequences select, swap, match-check, clear, refill and revert in response to cursor clicks.
- The VGA renderer reads tile codes through a combinational read port and uses sel/flash outputs to blink the selected cell.
- The cursor logic upstream converts pixel position into click_row/click_col.

Parameters:
FLASH_DIV, 2500000, clk cycles between flash_on toggles while a cell is selected
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
MAX_CASCADE, 4, max CHECK passes after a successful swap before forced return to IDLE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
click  in  1  one-cycle click pulse
click_row  in  2  clicked row; valid 0..2
click_col  in  2  clicked column; valid 0..2
rd_row  in  2  display read row
rd_col  in  2  display read column
rd_tile  out  2  tile code at (rd_row, rd_col), combinational; 0 if out of range
sel_valid  out  1  a first cell is selected
sel_row  out  2  selected row
sel_col  out  2  selected column
flash_on  out  1  renderer draws the selected cell when 1
busy  out  1  high in SWAP/CHECK/UNSWAP/CLEAR/REFILL
swap_done  out  1  one-cycle pulse: accepted swap fully resolved
swap_rejected  out  1  one-cycle pulse: swap produced no match and was reverted
score  out  8  cumulative cleared-cell count, saturates at 255

Behaviour:
- Reset (synchronous, any state, mid-operation included):
  - board rows loaded as r0 = 0 0 1, r1 = 1 1 0, r2 = 2 2 3.
  - state IDLE, sel_valid=0, sel_row/col=0, flash_on=1, busy=0, pulses 0, score=0, LFSR=LFSR_SEED, cascade count 0.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts right every clk cycle except during reset, in all states.
- Click validity: a click with a coordinate >2 is ignored in every state. Clicks while busy=1 are ignored and not queued.
- IDLE: valid click latches sel_row/col, sets sel_valid=1, goes to SEL1.
- SEL1, on a valid click:
  - same cell: sel_valid=0, return to IDLE.
  - orthogonally adjacent cell (|dr|+|dc|=1): latch it as the second cell, go to SWAP. busy rises the next cycle.
  - any other cell: re-select it and stay in SEL1.
- SWAP (1 cycle): exchange the two cells; cascade count=0; go to CHECK.
- CHECK (1 cycle):
  - Match mask: a cell is marked if its whole row or whole column holds identical codes.
  - Mask nonzero and count < MAX_CASCADE: go to CLEAR.
  - Mask zero on first pass: go to UNSWAP.
  - Mask zero after any refill, or count == MAX_CASCADE: go to IDLE, pulse swap_done, sel_valid=0.
- UNSWAP (1 cycle): exchange the two cells back, pulse swap_rejected, sel_valid=0, go to IDLE.
- CLEAR (1 cycle): score += popcount(mask), saturating at 255; hold mask; go to REFILL.
- REFILL (9 cycles, scan index k=0..8, row-major):
  - if mask bit k is set, cell k = LFSR[1:0] of that cycle.
  - after k=8: cascade count+1, go to CHECK.
- Latency: accepted swap to swap_rejected is 3 cycles after the second click (SWAP, CHECK, UNSWAP). One clear/refill pass is 11 cycles.
- Flash:
  - counter clears and flash_on=1 on every new selection.
  - while sel_valid=1, flash_on toggles every FLASH_DIV cycles.
  - while sel_valid=0, flash_on=1 and the counter is held at 0.
- Board writes occur only in SWAP, UNSWAP and REFILL. rd_tile reflects writes the cycle after they occur.

Test Plan:
- Reset, then sweep rd_row/rd_col over all 9 cells -> returns 0,0,1 / 1,1,0 / 2,2,3; score=0, sel_valid=0, flash_on=1.
- Click (0,2) then (1,2) -> after SWAP, r0=000 and r1=111; CLEAR adds 6 to score; 9 REFILL cycles; swap_done pulses once; score>=6 matches bench LFSR model; busy low afterwards.
- Click (2,1) then (2,2) -> tiles swapped one cycle then restored to r2=2 2 3; swap_rejected pulses exactly 3 cycles after the second click; score unchanged.
- Click (0,0), then (2,2) [non-adjacent], then (2,2) [same cell] -> sel moves to (2,2), then sel_valid=0; no board change.
- With FLASH_DIV=4, click (1,1) and hold -> flash_on=1 for 4 cycles, then toggles every 4 cycles. Clicks at (3,0), and any click during busy, are ignored.
- Assert reset during REFILL k=4 -> next cycle: initial board, IDLE, score=0, LFSR=LFSR_SEED, no pulses.

Source files
------------

// File: rtl/tile_swap_controller_if.sv
// Handshake/bus bundle between the tile-swap controller and its neighbours:
// cursor clicks in, display read port, selection/flash and status out.
interface tile_swap_controller_if;
    logic       click;
    logic [1:0] click_row;
    logic [1:0] click_col;
    logic [1:0] rd_row;
    logic [1:0] rd_col;
    logic [1:0] rd_tile;
    logic       sel_valid;
    logic [1:0] sel_row;
    logic [1:0] sel_col;
    logic       flash_on;
    logic       busy;
    logic       swap_done;
    logic       swap_rejected;
    logic [7:0] score;

    // Upstream cursor logic / renderer side.
    modport master (
        output click, click_row, click_col, rd_row, rd_col,
        input  rd_tile, sel_valid, sel_row, sel_col, flash_on, busy,
               swap_done, swap_rejected, score
    );

    // Controller side.
    modport slave (
        input  click, click_row, click_col, rd_row, rd_col,
        output rd_tile, sel_valid, sel_row, sel_col, flash_on, busy,
               swap_done, swap_rejected, score
    );
endinterface

// File: rtl/tile_swap_controller.sv
// 3x3 tile board owner: click selection, swap, match check, clear, refill
// from an LFSR, and revert of non-matching swaps. Cells are indexed
// row-major (k = row*3 + col).
module tile_swap_controller #(
    parameter int          FLASH_DIV   = 2500000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          MAX_CASCADE = 4
) (
    input  logic clk,
    input  logic reset,
    tile_swap_controller_if.slave bus
);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam int CW = (MAX_CASCADE > 0) ? $clog2(MAX_CASCADE + 1) : 1;
    localparam logic [CW-1:0] CASC_MAX = CW'(MAX_CASCADE);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL1, S_SWAP, S_CHECK, S_UNSWAP, S_CLEAR, S_REFILL
    } state_t;

    state_t          state_q;
    logic [8:0][1:0] board_q;
    logic            sel_valid_q;
    logic [1:0]      sel_row_q, sel_col_q;
    logic [1:0]      sec_row_q, sec_col_q;
    logic            flash_q;
    logic [FW-1:0]   flash_cnt_q;
    logic            swap_done_q, swap_rej_q;
    logic [7:0]      score_q;
    logic [15:0]     lfsr_q;
    logic [CW-1:0]   casc_q;
    logic [8:0]      mask_q;
    logic [3:0]      k_q;

    function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
        return {2'b00, r} * 4'd3 + {2'b00, c};
    endfunction

    logic       click_ok, same_cell, adj_cell;
    logic [3:0] ia, ib, rd_idx;
    logic [8:0] match;
    logic [3:0] pop;
    logic [8:0] score_sum;

    // A click counts only with both coordinates on the board.
    assign click_ok  = bus.click && (bus.click_row <= 2'd2) && (bus.click_col <= 2'd2);
    assign same_cell = (bus.click_row == sel_row_q) && (bus.click_col == sel_col_q);
    assign adj_cell  = ((bus.click_row == sel_row_q) &&
                        ((bus.click_col == 2'(sel_col_q + 2'd1)) || (sel_col_q == 2'(bus.click_col + 2'd1)))) ||
                       ((bus.click_col == sel_col_q) &&
                        ((bus.click_row == 2'(sel_row_q + 2'd1)) || (sel_row_q == 2'(bus.click_row + 2'd1))));

    assign ia     = cell_idx(sel_row_q, sel_col_q);
    assign ib     = cell_idx(sec_row_q, sec_col_q);
    assign rd_idx = cell_idx(bus.rd_row, bus.rd_col);

    // Match mask: mark every cell of a row or column holding one code.
    always_comb begin
        match = '0;
        for (int r = 0; r < 3; r++) begin
            if (board_q[3*r] == board_q[3*r+1] && board_q[3*r] == board_q[3*r+2])
                match = match | (9'b000000111 << (3*r));
        end
        for (int c = 0; c < 3; c++) begin
            if (board_q[c] == board_q[c+3] && board_q[c] == board_q[c+6])
                match = match | (9'b001001001 << c);
        end
    end

    // Number of cells cleared by the held mask, and the saturating score sum.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 9; i++) pop = pop + 4'(mask_q[i]);
        score_sum = {1'b0, score_q} + {5'b00000, pop};
    end

    // Free-running Galois LFSR feeding refill codes.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Main sequencer: selection, board updates, score, pulses and flash.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            board_q     <= {2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
            sel_valid_q <= 1'b0;
            sel_row_q   <= '0;
            sel_col_q   <= '0;
            sec_row_q   <= '0;
            sec_col_q   <= '0;
            flash_q     <= 1'b1;
            flash_cnt_q <= '0;
            swap_done_q <= 1'b0;
            swap_rej_q  <= 1'b0;
            score_q     <= '0;
            casc_q      <= '0;
            mask_q      <= '0;
            k_q         <= '0;
        end else begin
            swap_done_q <= 1'b0;
            swap_rej_q  <= 1'b0;
            // Blink while a cell is selected; branches below that change
            // the selection override this with a fresh count.
            if (sel_valid_q) begin
                if (flash_cnt_q == FLASH_LAST) begin
                    flash_cnt_q <= '0;
                    flash_q     <= ~flash_q;
                end else begin
                    flash_cnt_q <= flash_cnt_q + 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (click_ok) begin
                        sel_row_q   <= bus.click_row;
                        sel_col_q   <= bus.click_col;
                        sel_valid_q <= 1'b1;
                        flash_cnt_q <= '0;
                        flash_q     <= 1'b1;
                        state_q     <= S_SEL1;
                    end
                end
                S_SEL1: begin
                    if (click_ok) begin
                        if (same_cell) begin
                            sel_valid_q <= 1'b0;
                            flash_cnt_q <= '0;
                            flash_q     <= 1'b1;
                            state_q     <= S_IDLE;
                        end else if (adj_cell) begin
                            sec_row_q <= bus.click_row;
                            sec_col_q <= bus.click_col;
                            state_q   <= S_SWAP;
                        end else begin
                            sel_row_q   <= bus.click_row;
                            sel_col_q   <= bus.click_col;
                            flash_cnt_q <= '0;
                            flash_q     <= 1'b1;
                        end
                    end
                end
                S_SWAP: begin
                    board_q[ia] <= board_q[ib];
                    board_q[ib] <= board_q[ia];
                    casc_q      <= '0;
                    state_q     <= S_CHECK;
                end
                S_CHECK: begin
                    mask_q <= match;
                    if (match != 9'd0 && casc_q < CASC_MAX) begin
                        state_q <= S_CLEAR;
                    end else if (match == 9'd0 && casc_q == '0) begin
                        state_q <= S_UNSWAP;
                    end else begin
                        swap_done_q <= 1'b1;
                        sel_valid_q <= 1'b0;
                        flash_cnt_q <= '0;
                        flash_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_UNSWAP: begin
                    board_q[ia] <= board_q[ib];
                    board_q[ib] <= board_q[ia];
                    swap_rej_q  <= 1'b1;
                    sel_valid_q <= 1'b0;
                    flash_cnt_q <= '0;
                    flash_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_CLEAR: begin
                    score_q <= score_sum[8] ? 8'd255 : score_sum[7:0];
                    k_q     <= '0;
                    state_q <= S_REFILL;
                end
                S_REFILL: begin
                    if (mask_q[k_q]) board_q[k_q] <= lfsr_q[1:0];
                    if (k_q == 4'd8) begin
                        casc_q  <= casc_q + 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_tile       = (bus.rd_row > 2'd2 || bus.rd_col > 2'd2) ? 2'd0 : board_q[rd_idx];
    assign bus.sel_valid     = sel_valid_q;
    assign bus.sel_row       = sel_row_q;
    assign bus.sel_col       = sel_col_q;
    assign bus.flash_on      = flash_q;
    assign bus.busy          = (state_q == S_SWAP) || (state_q == S_CHECK) || (state_q == S_UNSWAP) ||
                               (state_q == S_CLEAR) || (state_q == S_REFILL);
    assign bus.swap_done     = swap_done_q;
    assign bus.swap_rejected = swap_rej_q;
    assign bus.score         = score_q;
endmodule

// File: tb/tb_tile_swap_controller.sv
// Bench for tile_swap_controller: directed scenarios plus random clicking,
// all checked against a transaction-level model of the game rules.
module tb_tile_swap_controller;
    localparam int          FD   = 4;
    localparam int          MC   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tile_swap_controller_if bus();

    tile_swap_controller #(.FLASH_DIV(FD), .LFSR_SEED(SEED), .MAX_CASCADE(MC)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          mb[9];
    bit          m_sv;
    int          m_sr, m_sc;
    int          m_score;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] ladv(input logic [15:0] l, input int n);
        logic [15:0] x = l;
        for (int i = 0; i < n; i++) x = lstep(x);
        return x;
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lstep(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        int init[9] = '{0, 0, 1, 1, 1, 0, 2, 2, 3};
        mb = init;
        m_sv = 0; m_sr = 0; m_sc = 0; m_score = 0;
    endtask

    function automatic bit [8:0] mmask(input int b[9]);
        bit [8:0] m = '0;
        for (int r = 0; r < 3; r++)
            if (b[3*r] == b[3*r+1] && b[3*r] == b[3*r+2]) begin
                m[3*r] = 1; m[3*r+1] = 1; m[3*r+2] = 1;
            end
        for (int c = 0; c < 3; c++)
            if (b[c] == b[c+3] && b[c] == b[c+6]) begin
                m[c] = 1; m[c+3] = 1; m[c+6] = 1;
            end
        return m;
    endfunction

    task automatic rd_cell(input int r, input int c, output int v);
        bus.rd_row = 2'(r);
        bus.rd_col = 2'(c);
        #1;
        v = int'(bus.rd_tile);
    endtask

    task automatic sweep(input string tag);
        int v;
        for (int i = 0; i < 9; i++) begin
            rd_cell(i / 3, i % 3, v);
            chk($sformatf("%s_cell%0d", tag, i), v, mb[i]);
        end
        rd_cell(3, 0, v);
        chk({tag, "_oob"}, v, 0);
    endtask

    // Predict a whole swap transaction: final board, score, outcome and the
    // cycle (counted in clock edges after the accepting click) of its pulse.
    task automatic predict(input int a, input int b, input logic [15:0] l0,
                           output bit rej, output int exp_j);
        int t; int p; bit [8:0] m; int pc;
        t = mb[a]; mb[a] = mb[b]; mb[b] = t;
        p = 0;
        forever begin
            m = mmask(mb);
            if (m != 0 && p < MC) begin
                pc = $countones(m);
                m_score = (m_score + pc > 255) ? 255 : m_score + pc;
                for (int k = 0; k < 9; k++)
                    if (m[k]) mb[k] = int'(ladv(l0, 4 + 11*p + k) & 16'h3);
                p++;
            end else if (m == 0 && p == 0) begin
                t = mb[a]; mb[a] = mb[b]; mb[b] = t;
                rej = 1; exp_j = 3;
                break;
            end else begin
                rej = 0; exp_j = 2 + 11*p;
                break;
            end
        end
    endtask

    task automatic do_click(input int r, input int c);
        bit valid, is_swap, newsel, rej, seen;
        int a, b, va, vb, exp_j, v, jj;
        logic [15:0] l0;
        @(negedge clk);
        l0 = m_lfsr;
        bus.click = 1; bus.click_row = 2'(r); bus.click_col = 2'(c);
        valid = (r <= 2) && (c <= 2);
        is_swap = 0; newsel = 0;
        if (valid) begin
            if (!m_sv) begin
                m_sv = 1; m_sr = r; m_sc = c; newsel = 1;
            end else if (r == m_sr && c == m_sc) begin
                m_sv = 0;
            end else if ((r == m_sr && (c - m_sc == 1 || m_sc - c == 1)) ||
                         (c == m_sc && (r - m_sr == 1 || m_sr - r == 1))) begin
                is_swap = 1;
            end else begin
                m_sr = r; m_sc = c; newsel = 1;
            end
        end
        @(negedge clk);
        bus.click = 0;
        if (!is_swap) begin
            chk("sel_valid", bus.sel_valid, m_sv);
            if (m_sv) begin
                chk("sel_row", bus.sel_row, m_sr);
                chk("sel_col", bus.sel_col, m_sc);
            end
            if (newsel || !m_sv) chk("flash_sel", bus.flash_on, 1);
            chk("busy_idle", bus.busy, 0);
            return;
        end
        a = 3*m_sr + m_sc;
        b = 3*r + c;
        va = mb[b]; vb = mb[a];
        predict(a, b, l0, rej, exp_j);
        chk("busy_start", bus.busy, 1);
        seen = 0;
        for (int j = 1; j <= 300; j++) begin
            @(negedge clk);
            if (j == 1) begin
                rd_cell(a / 3, a % 3, v); chk("swap_a", v, va);
                rd_cell(b / 3, b % 3, v); chk("swap_b", v, vb);
            end
            if (j == 2) begin
                bus.click = 1;
                bus.click_row = 2'($urandom_range(0, 2));
                bus.click_col = 2'($urandom_range(0, 2));
            end
            if (j == 3) bus.click = 0;
            if (bus.swap_done || bus.swap_rejected) begin
                jj = j; seen = 1;
                chk("pulse_cycle", jj, exp_j);
                chk("pulse_rej", bus.swap_rejected, rej);
                chk("pulse_done", bus.swap_done, !rej);
                chk("busy_end", bus.busy, 0);
                chk("sel_clear", bus.sel_valid, 0);
                chk("flash_end", bus.flash_on, 1);
                break;
            end
        end
        bus.click = 0;
        if (!seen) chk("pulse_timeout", 0, 1);
        m_sv = 0;
        @(negedge clk);
        chk("pulse_width", {bus.swap_done, bus.swap_rejected}, 0);
        chk("score", bus.score, m_score);
        sweep("board");
    endtask

    initial begin
        bus.click = 0; bus.click_row = 0; bus.click_col = 0;
        bus.rd_row = 0; bus.rd_col = 0;
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sel_valid", bus.sel_valid, 0);
        chk("rst_sel_rc", {bus.sel_row, bus.sel_col}, 0);
        chk("rst_flash", bus.flash_on, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pulses", {bus.swap_done, bus.swap_rejected}, 0);
        chk("rst_score", bus.score, 0);
        reset = 0;
        sweep("init");

        // Rejected swap on the bottom row.
        do_click(2, 1);
        do_click(2, 2);
        // Non-adjacent reselect, then same-cell deselect.
        do_click(0, 0);
        do_click(2, 2);
        do_click(2, 2);
        sweep("nochange");
        // Accepted swap making two full rows.
        do_click(0, 2);
        do_click(1, 2);
        chk("score_min6", bus.score >= 6, 1);

        // Flash cadence with an out-of-range click in the middle.
        @(negedge clk);
        bus.click = 1; bus.click_row = 1; bus.click_col = 1;
        @(negedge clk);
        bus.click = 0;
        m_sv = 1; m_sr = 1; m_sc = 1;
        chk("flash_j0", bus.flash_on, 1);
        for (int j = 1; j < 16; j++) begin
            @(negedge clk);
            if (j == 5) begin bus.click = 1; bus.click_row = 3; bus.click_col = 0; end
            if (j == 6) bus.click = 0;
            chk($sformatf("flash_j%0d", j), bus.flash_on, ((j / 4) % 2) == 0);
        end
        chk("flash_sel_row", bus.sel_row, 1);
        chk("flash_sel_col", bus.sel_col, 1);
        do_click(1, 1);

        // Reset in the middle of REFILL (k=4 pending).
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        do_click(0, 2);
        @(negedge clk);
        bus.click = 1; bus.click_row = 1; bus.click_col = 2;
        @(negedge clk);
        bus.click = 0;
        repeat (7) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_sel", bus.sel_valid, 0);
        chk("mid_rst_score", bus.score, 0);
        chk("mid_rst_pulses", {bus.swap_done, bus.swap_rejected}, 0);
        chk("mid_rst_flash", bus.flash_on, 1);
        reset = 0;
        model_reset();
        sweep("mid_rst");
        do_click(0, 2);
        do_click(1, 2);

        // Random clicking against the model.
        for (int i = 0; i < 80; i++) begin
            int r, c;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            c = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            do_click(r, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
